// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight writers per stage to drive D-stage stall and operand forward selects.
module hazard_scoreboard #(
  parameter int DEPTH   = 3,
  parameter int TNEW_W  = 2,
  parameter int MDU_LAT = 5,
  parameter int SEL_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              issue_valid,
  input  logic [4:0]        issue_rd,
  input  logic [TNEW_W-1:0] issue_tnew,
  input  logic              issue_md_start,
  input  logic              issue_md_use,
  input  logic              issue_epc_wr,
  input  logic              issue_eret,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [TNEW_W-1:0] tuse_rs,
  input  logic [TNEW_W-1:0] tuse_rt,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_rs_sel,
  output logic [SEL_W-1:0]  fwd_rt_sel,
  output logic              md_busy
);
  localparam int CW = $clog2(MDU_LAT + 1);
  logic [DEPTH-1:0] valid_q, valid_d, epc_q, epc_d, md_q, md_d;
  logic [DEPTH-1:0][4:0] rd_q, rd_d;
  logic [DEPTH-1:0][TNEW_W-1:0] tnew_q, tnew_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TNEW_W-1:0] mt_rs, mt_rt;
  logic hit_rs, hit_rt, any_epc, stall_rs, stall_rt, stall_md, stall_eret, accept;
  assign md_busy = cnt_q != '0;
  // Walk oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    fwd_rs_sel = '0;
    fwd_rt_sel = '0;
    hit_rs = 1'b0;
    hit_rt = 1'b0;
    mt_rs = '0;
    mt_rt = '0;
    any_epc = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (valid_q[k] && rd_q[k] != 5'd0 && rd_q[k] == rs) begin
        hit_rs = 1'b1;
        mt_rs = tnew_q[k];
        fwd_rs_sel = SEL_W'(k + 1);
      end
      if (valid_q[k] && rd_q[k] != 5'd0 && rd_q[k] == rt) begin
        hit_rt = 1'b1;
        mt_rt = tnew_q[k];
        fwd_rt_sel = SEL_W'(k + 1);
      end
      any_epc = any_epc | (valid_q[k] & epc_q[k]);
    end
    stall_rs = hit_rs && mt_rs > tuse_rs;
    stall_rt = hit_rt && mt_rt > tuse_rt;
    stall_md = issue_md_use && (md_busy || (valid_q[0] && md_q[0]));
    stall_eret = issue_eret && any_epc;
    stall = issue_valid && (stall_rs || stall_rt || stall_md || stall_eret);
  end
  always_comb begin
    accept = issue_valid && !stall && !flush;
    valid_d[0] = accept;
    rd_d[0] = accept ? issue_rd : '0;
    tnew_d[0] = accept ? issue_tnew : '0;
    epc_d[0] = accept & issue_epc_wr;
    md_d[0] = accept & issue_md_start;
    for (int k = 1; k < DEPTH; k++) begin
      valid_d[k] = valid_q[k-1];
      rd_d[k] = rd_q[k-1];
      tnew_d[k] = tnew_q[k-1] - TNEW_W'(tnew_q[k-1] != '0);
      epc_d[k] = epc_q[k-1];
      md_d[k] = md_q[k-1];
    end
    if (flush) begin
      valid_d = '0;
      rd_d = '0;
      tnew_d = '0;
      epc_d = '0;
      md_d = '0;
    end
    // The MDU starts counting once the mult/div has reached E.
    cnt_d = flush ? '0 : (valid_q[0] && md_q[0]) ? CW'(MDU_LAT) : cnt_q - CW'(md_busy);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      rd_q <= '0;
      tnew_q <= '0;
      epc_q <= '0;
      md_q <= '0;
      cnt_q <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q <= rd_d;
      tnew_q <= tnew_d;
      epc_q <= epc_d;
      md_q <= md_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: scenario tasks push expected {stall, fwd_rs_sel, fwd_rt_sel, md_busy} and compare each cycle.
module tb_hazard_scoreboard;
  logic clk = 0, reset = 0, flush = 0, issue_valid = 0, issue_md_start = 0, issue_md_use = 0;
  logic issue_epc_wr = 0, issue_eret = 0, stall, md_busy;
  logic [4:0] issue_rd = 0, rs = 0, rt = 0;
  logic [1:0] issue_tnew = 0, tuse_rs = 0, tuse_rt = 0, fwd_rs_sel, fwd_rt_sel;
  logic [5:0] obs, e;
  logic [5:0] q[$];
  int n_run = 0, n_fail = 0;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .flush(flush), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_tnew(issue_tnew), .issue_md_start(issue_md_start), .issue_md_use(issue_md_use),
    .issue_epc_wr(issue_epc_wr), .issue_eret(issue_eret), .rs(rs), .rt(rt),
    .tuse_rs(tuse_rs), .tuse_rt(tuse_rt), .stall(stall), .fwd_rs_sel(fwd_rs_sel),
    .fwd_rt_sel(fwd_rt_sel), .md_busy(md_busy)
  );

  always #5 clk = ~clk;
  assign obs = {stall, fwd_rs_sel, fwd_rt_sel, md_busy};

  function automatic logic [5:0] ex(input logic s, input logic [1:0] a, input logic [1:0] b, input logic m);
    return {s, a, b, m};
  endfunction

  task automatic drive(input logic v, input logic [4:0] d, input logic [1:0] tn, input logic ms,
                       input logic mu, input logic ep, input logic er, input logic [4:0] s,
                       input logic [4:0] t, input logic [1:0] us, input logic [1:0] ut, input logic fl);
    issue_valid = v; issue_rd = d; issue_tnew = tn; issue_md_start = ms; issue_md_use = mu;
    issue_epc_wr = ep; issue_eret = er; rs = s; rt = t; tuse_rs = us; tuse_rt = ut; flush = fl;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 0;
    drive(1, 2, 2, 1, 1, 1, 1, 2, 2, 0, 0, 0);
    #2;
    q.push_back(ex(0, 0, 0, 0));
    e = q.pop_front(); n_run++;
    if (obs !== e) begin n_fail++; $display("FAIL reset got=%b exp=%b", obs, e); end
    idle(1);
    @(negedge clk) reset = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_use;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(1, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      else drive(1, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0);
      q.push_back(i == 0 ? ex(0, 0, 0, 0) : i == 1 ? ex(1, 1, 0, 0) : ex(0, 2, 0, 0));
      @(negedge clk); e = q.pop_front(); n_run++;
      if (obs !== e) begin n_fail++; $display("FAIL load_use c%0d got=%b exp=%b", i, obs, e); end
      @(posedge clk); #1;
    end
    idle(4);
  endtask

  task automatic test_zero_reg;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) drive(1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      else drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      q.push_back(ex(0, 0, 0, 0));
      @(negedge clk); e = q.pop_front(); n_run++;
      if (obs !== e) begin n_fail++; $display("FAIL zero_reg c%0d got=%b exp=%b", i, obs, e); end
      @(posedge clk); #1;
    end
    idle(4);
  endtask

  task automatic test_shadow;
    for (int i = 0; i < 4; i++) begin
      if (i < 2) drive(1, 3, i == 0 ? 2'd2 : 2'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      else drive(1, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0);
      q.push_back(i < 2 ? ex(0, 0, 0, 0) : i == 2 ? ex(1, 0, 1, 0) : ex(0, 0, 2, 0));
      @(negedge clk); e = q.pop_front(); n_run++;
      if (obs !== e) begin n_fail++; $display("FAIL shadow c%0d got=%b exp=%b", i, obs, e); end
      @(posedge clk); #1;
    end
    idle(4);
  endtask

  task automatic test_mdu;
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, i == 0, 1, 0, 0, 0, 0, 0, 0, 0);
      q.push_back(i == 0 || i == 7 ? ex(0, 0, 0, 0) : ex(1, 0, 0, i >= 2));
      @(negedge clk); e = q.pop_front(); n_run++;
      if (obs !== e) begin n_fail++; $display("FAIL mdu c%0d got=%b exp=%b", i, obs, e); end
      @(posedge clk); #1;
    end
    idle(4);
  endtask

  task automatic test_epc;
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0, 0, i == 0, i != 0, 0, 0, 0, 0, 0);
      q.push_back(ex(i >= 1 && i <= 3, 0, 0, 0));
      @(negedge clk); e = q.pop_front(); n_run++;
      if (obs !== e) begin n_fail++; $display("FAIL epc c%0d got=%b exp=%b", i, obs, e); end
      @(posedge clk); #1;
    end
    idle(4);
  endtask

  task automatic test_flush;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(1, 0, 0, i == 0, 1, 0, 0, 0, 0, 0, 0, i == 2);
      else if (i == 4) drive(1, 5, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      else drive(1, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0);
      q.push_back(i == 1 ? ex(1, 0, 0, 0) : i == 2 ? ex(1, 0, 0, 1) : ex(0, 0, 0, 0));
      @(negedge clk); e = q.pop_front(); n_run++;
      if (obs !== e) begin n_fail++; $display("FAIL flush c%0d got=%b exp=%b", i, obs, e); end
      @(posedge clk); #1;
    end
    idle(4);
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, i == 0, 1, 0, 0, 0, 0, 0, 0, 0);
      q.push_back(i == 0 ? ex(0, 0, 0, 0) : ex(1, 0, 0, i == 2));
      @(negedge clk); e = q.pop_front(); n_run++;
      if (obs !== e) begin n_fail++; $display("FAIL reset_mid c%0d got=%b exp=%b", i, obs, e); end
      if (i < 2) begin @(posedge clk); #1; end
    end
    #1 reset = 0;
    #1 q.push_back(ex(0, 0, 0, 0));
    e = q.pop_front(); n_run++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_mid_async got=%b exp=%b", obs, e); end
    #1 reset = 1;
    @(posedge clk); #1;
    for (int i = 3; i < 5; i++) begin
      if (i == 3) drive(1, 9, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      else drive(1, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 0);
      q.push_back(i == 3 ? ex(0, 0, 0, 0) : ex(1, 1, 0, 0));
      @(negedge clk); e = q.pop_front(); n_run++;
      if (obs !== e) begin n_fail++; $display("FAIL reset_mid c%0d got=%b exp=%b", i, obs, e); end
      @(posedge clk); #1;
    end
    idle(4);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) drive(1, 4, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      else if (i == 1) drive(1, 6, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      else drive(1, 0, 0, 0, 0, 0, 0, 4, 6, 0, 0, 0);
      q.push_back(i < 2 ? ex(0, 0, 0, 0) : i == 2 ? ex(1, 2, 1, 0) : i == 3 ? ex(1, 3, 2, 0) : ex(0, 0, 3, 0));
      @(negedge clk); e = q.pop_front(); n_run++;
      if (obs !== e) begin n_fail++; $display("FAIL back_to_back c%0d got=%b exp=%b", i, obs, e); end
      @(posedge clk); #1;
    end
    idle(4);
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: drive(1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        1: drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        2: drive(1, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0);
        3: drive(1, 8, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        default: drive(0, 0, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0);
      endcase
      q.push_back(i == 2 ? ex(0, 2, 0, 0) : i == 4 ? ex(0, 1, 0, 0) : ex(0, 0, 0, 0));
      @(negedge clk); e = q.pop_front(); n_run++;
      if (obs !== e) begin n_fail++; $display("FAIL saturate c%0d got=%b exp=%b", i, obs, e); end
      @(posedge clk); #1;
    end
    idle(4);
  endtask

  initial begin
    test_reset;
    test_load_use;
    test_zero_reg;
    test_shadow;
    test_mdu;
    test_epc;
    test_flush;
    test_reset_mid;
    test_back_to_back;
    test_saturate;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset; port list starts with clock and reset as below.
REQ-002 Parameter DEPTH, default 3, SHALL set the number of tracked post-decode stages; stage 0 = E, 1 = M, 2 = W.
REQ-003 Parameter TNEW_W, default 2, SHALL set the width of Tnew and Tuse fields.
REQ-004 Parameter MDU_LAT, default 5, SHALL set the multiply/divide busy cycles.
REQ-005 Parameter SEL_W, default 2, SHALL set the forward-select width; the design requires 2^SEL_W > DEPTH.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  asynchronous active-low reset; 0 = reset.
REQ-008 flush  input  1  synchronous pipeline flush from exception or interrupt.
REQ-009 issue_valid  input  1  D holds a valid instruction.
REQ-010 issue_rd  input  5  destination GPR of the D instruction; 0 = no write.
REQ-011 issue_tnew  input  TNEW_W  cycles from E entry until the result is ready.
REQ-012 issue_md_start  input  1  D instruction starts mult or div.
REQ-013 issue_md_use  input  1  D instruction is mfhi, mflo, mthi, mtlo, mult or div.
REQ-014 issue_epc_wr  input  1  D instruction is mtc0 to CP0 register 14.
REQ-015 issue_eret  input  1  D instruction is eret.
REQ-016 rs, rt  input  5 each  source GPRs read by D.
REQ-017 tuse_rs, tuse_rt  input  TNEW_W each  cycles until D needs each operand.
REQ-018 stall  output  1  freeze F and D; insert a bubble into E.
REQ-019 fwd_rs_sel, fwd_rt_sel  output  SEL_W each  0 = register file; k+1 = youngest matching stage k.
REQ-020 md_busy  output  1  MDU busy counter is non-zero.

Function
REQ-021 Each stage k SHALL hold an entry {valid, rd, tnew, epc_wr}.
REQ-022 Each clock SHALL shift every entry from stage k to stage k+1; the entry leaving stage DEPTH-1 is discarded.
REQ-023 Tnew SHALL decrement by 1 per shift and saturate at 0, never wrapping.
REQ-024 Stage 0 SHALL load {issue_valid, issue_rd, issue_tnew, issue_epc_wr} when issue_valid=1 and stall=0.
REQ-025 Stage 0 SHALL load an invalid, all-zero bubble when stall=1 or issue_valid=0.
REQ-026 A match SHALL require valid=1, rd equal to the source register, and rd != 0; $0 SHALL never match, stall or forward.
REQ-027 Only the youngest matching stage (lowest k) SHALL count for a source; older matches are shadowed.
REQ-028 stall_rs SHALL be asserted when the youngest match has tnew > tuse_rs; stall_rt SHALL follow the same rule for rt.
REQ-029 stall_md SHALL be asserted when issue_md_use=1 and either md_busy=1 or a valid stage-0 entry has md_start.
REQ-030 Each stage SHALL carry an md_start bit alongside its entry for the stall_md check.
REQ-031 stall_eret SHALL be asserted when issue_eret=1 and any valid entry has epc_wr=1.
REQ-032 stall SHALL equal issue_valid AND (stall_rs OR stall_rt OR stall_md OR stall_eret), computed combinationally from current state and inputs.
REQ-033 fwd_*_sel SHALL report the youngest match regardless of tnew, and SHALL be 0 when there is no match.
REQ-034 The MDU counter SHALL load MDU_LAT one clock after an accepted issue_md_start, then decrement to 0 and hold.
REQ-035 md_busy SHALL equal (counter != 0).
REQ-036 flush=1 SHALL invalidate all stages and clear the MDU counter on the next edge.
REQ-037 A D issue presented in the same cycle as flush=1 SHALL be dropped; flush has priority.
REQ-038 Simultaneous rs and rt hazards SHALL produce a single stall; both sel outputs SHALL remain independently valid.

Reset
REQ-039 While reset=0, all entries SHALL be invalid and zero, the MDU counter SHALL be 0, and md_busy SHALL be 0.
REQ-040 While reset=0, stall SHALL be 0 and fwd_rs_sel and fwd_rt_sel SHALL be 0.
REQ-041 Reset asserted mid-operation SHALL clear state immediately without waiting for a clock edge.
REQ-042 After reset release, the first edge SHALL behave as an ordinary cycle.

Verification
REQ-043 Load-use: lw rd=2, tnew=2 issued at cycle 0; at cycle 1 addu rs=2, tuse=1 -> stall=1, fwd_rs_sel=1; at cycle 2 -> stall=0, fwd_rs_sel=2.
REQ-044 Zero register: writer rd=0, tnew=2, then reader rs=0, tuse=0 -> stall=0, fwd_rs_sel=0.
REQ-045 Shadowing: rd=3 tnew=2 issued, then rd=3 tnew=1 issued; at cycle 2 reader rt=3, tuse=0 -> youngest entry (stage 0, tnew=1) governs, stall=1, fwd_rt_sel=1.
REQ-046 MDU: mult accepted at cycle 0, mfhi in D from cycle 1 -> stall=1 for cycles 1..6, accepted at cycle 7 (md_busy 1 during cycles 2..6).
REQ-047 EPC: mtc0 $14 accepted, eret next in D -> stall=1 for exactly DEPTH=3 cycles, then accepted.
REQ-048 Flush and reset: flush during the REQ-046 stall -> md_busy=0 and stall=0 next cycle; reset=0 pulsed mid-stall between edges -> stall=0 immediately.
